// File: rtl/expe_pkg.sv
// Shared types and helpers for the experiment-select block: code field widths,
// the all-off code, the FSM state encoding and code field extractors.
package expe_pkg;

    localparam int          GRP_W    = 4;
    localparam int          IDX_W    = 4;
    localparam logic [7:0]  CODE_OFF = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GUARD  = 2'd2
    } state_e;

    function automatic logic [GRP_W-1:0] code_grp(input logic [7:0] code);
        return code[7:4];
    endfunction

    function automatic logic [IDX_W-1:0] code_idx(input logic [7:0] code);
        return code[3:0];
    endfunction

endpackage

// File: rtl/expe_code_decode.sv
// Combinational check of an experiment code against the per-group slot counts,
// producing a legality flag and the one-hot enable pattern for that code.
module expe_code_decode
    import expe_pkg::*;
#(
    parameter int                  GROUPS      = 4,
    parameter int                  MAX_IDX     = 9,
    parameter logic [4*GROUPS-1:0] GROUP_SIZES = 16'h6695
) (
    input  logic [7:0]                sel_code,
    output logic                      legal,
    output logic [GROUPS*MAX_IDX-1:0] onehot
);

    localparam int                EN_W = GROUPS * MAX_IDX;
    localparam logic [EN_W-1:0]   ONE  = {{(EN_W-1){1'b0}}, 1'b1};

    logic [GRP_W-1:0] grp;
    logic [IDX_W-1:0] idx;
    logic [3:0]       size;
    int               bitpos;

    always_comb begin
        grp    = code_grp(sel_code);
        idx    = code_idx(sel_code);
        size   = '0;
        bitpos = 0;
        legal  = 1'b0;
        onehot = '0;

        for (int g = 1; g <= GROUPS; g++) begin
            if (int'(grp) == g) begin
                size = GROUP_SIZES[(g-1)*4 +: 4];
            end
        end

        // All-off is legal but enables nothing; every other code needs both fields in range.
        if (sel_code == CODE_OFF) begin
            legal = 1'b1;
        end else if ((grp != '0) && (int'(grp) <= GROUPS) &&
                     (idx != '0) && (idx <= size) && (int'(idx) <= MAX_IDX)) begin
            legal  = 1'b1;
            bitpos = (int'(grp) - 1) * MAX_IDX + int'(idx) - 1;
            onehot = ONE << bitpos;
        end
    end

endmodule

// File: rtl/expe_select_seq.sv
// Registered experiment selector: valid/ready code intake, legality check,
// and break-before-make switching with a programmable all-off guard gap.
//
// Handshake: a request transfers on a rising edge where sel_valid and sel_ready
// are both high. sel_ready comes straight from a flop (low only during GUARD),
// so it never depends on sel_valid in the same cycle.
module expe_select_seq
    import expe_pkg::*;
#(
    parameter int                  GROUPS       = 4,
    parameter int                  MAX_IDX      = 9,
    parameter logic [4*GROUPS-1:0] GROUP_SIZES  = 16'h6695,
    parameter int                  GUARD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                sel_code,
    input  logic                      sel_valid,
    output logic                      sel_ready,
    output logic [GROUPS*MAX_IDX-1:0] en,
    output logic [7:0]                active,
    output logic                      busy,
    output logic                      sel_err,
    output logic [1:0]                dbg_state
);

    localparam int         EN_W       = GROUPS * MAX_IDX;
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        pend_q, pend_d;
    logic [EN_W-1:0]   pend_oh_q, pend_oh_d;
    logic [EN_W-1:0]   en_q, en_d;
    logic [7:0]        active_q, active_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;

    logic              code_legal;
    logic [EN_W-1:0]   code_oh;
    logic              accept;
    logic              take;

    expe_code_decode #(
        .GROUPS      (GROUPS),
        .MAX_IDX     (MAX_IDX),
        .GROUP_SIZES (GROUP_SIZES)
    ) u_decode (
        .sel_code (sel_code),
        .legal    (code_legal),
        .onehot   (code_oh)
    );

    assign accept = sel_valid & ready_q;
    // A legal code that matches what is already enabled is a no-op, not a switch.
    assign take   = accept & code_legal & (sel_code != active_q);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= CODE_OFF;
            pend_oh_q <= '0;
            en_q      <= '0;
            active_q  <= CODE_OFF;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_oh_q <= pend_oh_d;
            en_q      <= en_d;
            active_q  <= active_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACTIVE: begin
                if (take) state_d = GUARD;
            end
            GUARD: begin
                if (cnt_q == '0) state_d = (pend_q == CODE_OFF) ? IDLE : ACTIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_oh_d = pend_oh_q;
        en_d      = en_q;
        active_d  = active_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE, ACTIVE: begin
                err_d = accept & ~code_legal;
                if (take) begin
                    cnt_d     = GUARD_LOAD;
                    pend_d    = sel_code;
                    pend_oh_d = code_oh;
                    en_d      = '0;
                    active_d  = CODE_OFF;
                end
            end
            GUARD: begin
                if (cnt_q == '0) begin
                    en_d     = pend_oh_q;
                    active_d = pend_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                en_d     = '0;
                active_d = CODE_OFF;
            end
        endcase

        busy_d  = (state_d == GUARD);
        ready_d = (state_d != GUARD);
    end

    assign sel_ready = ready_q;
    assign en        = en_q;
    assign active    = active_q;
    assign busy      = busy_q;
    assign sel_err   = err_q;
    assign dbg_state = state_q;

endmodule
